fp_add2: RTL and testbench
==========================

# fp_add2

Pipelined IEEE-754-style floating-point adder with a configurable exponent and mantissa width; the default configuration is binary32. It takes two packed operands, adds them, and returns the result as separate registered sign, exponent and mantissa fields. It serves as the accumulation primitive in the CNN datapath, feeding adder trees and multiply-accumulate stages. It accepts one new operand pair every clock.

## Interface
- EXPONENT_WIDTH, 8, biased exponent width E; bias = 2^(E-1)-1
- MANTISSA_WIDTH, 23, stored fraction width M (hidden bit implicit)
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- A_FP  input  1+E+M  operand A, packed {sign, exponent, fraction}
- B_FP  input  1+E+M  operand B, same packing
- sign  output  1  result sign
- exponent  output  E  result biased exponent
- mantissa  output  M  result fraction (hidden bit dropped)

## Operation
- **Unpacking**
  - Exponent 0: the operand is zero. Subnormals are flushed to zero, so their fraction is ignored.
  - Exponent nonzero and not all-ones: significand = {1, fraction}.
- **Alignment**
  - Swap the operands so that the larger magnitude comes first. Compare exponent first, then fraction.
  - Right-shift the smaller significand by the exponent difference, into a datapath of M+1 bits plus guard, round and sticky bits.
  - Shift amounts of M+3 or more reduce the smaller significand to sticky only.
- **Add or subtract**
  - Equal signs: add the magnitudes, with a 1-bit carry.
  - Different signs: subtract the smaller magnitude from the larger.
  - The result sign is the sign of the larger-magnitude operand.
- **Normalization**
  - On carry-out: shift right by 1 and increment the exponent.
  - Otherwise: shift left by the leading-zero count and decrement the exponent by the same count.
- **Rounding**: round to nearest, ties to even, using the guard, round and sticky bits.
  - A rounding carry renormalizes the result, incrementing the exponent.
- **Zero results**
  - An exact zero result (e.g. x + -x, or 0 + 0) is output as all-zero (+0).
  - A result whose exponent underflows (≤ 0) is flushed to +0.
- **Overflow**: a result exponent ≥ 2^E-1 outputs ±infinity: exponent all-ones, mantissa 0, sign of the result.
- **Special operands** (exponent all-ones)
  - Any NaN operand, or +inf + -inf: canonical quiet NaN, i.e. sign 0, exponent all-ones, mantissa MSB 1 and the rest 0.
  - Otherwise an infinity operand passes through with its sign.
- **Zero operands**: one operand zero outputs the other operand exactly, with no rounding.

## Timing
- Latency: exactly 1 clock. Operands present before rising edge n appear on sign, exponent and mantissa after edge n.
  - All arithmetic is combinational.
  - The output fields are registered.
- Throughput: 1 result per clock. There is no handshake or valid signal, so the outputs track the inputs with one cycle of delay.
- Reset:
  - rst high at a rising edge clears sign, exponent and mantissa to 0, overriding that cycle's result.
  - The first valid result appears at the first edge with rst low.
- The inputs are not registered. They must be stable for setup before each rising edge.

## Test plan
- 4.0 (0x40800000) + -1.0 (0xBF800000) -> next edge: sign 0, exponent 0x80, mantissa 0x400000 (3.0).
- 7.25 (0x40E80000) + 0.375 (0x3EC00000) -> sign 0, exponent 0x81, mantissa 0x740000 (7.625).
  - Back-to-back in the following cycle: 6 (0x40C00000) + 7 (0x40E00000) -> exponent 0x82, mantissa 0x500000 (13).
- Cancellation cases:
  - 65 (0x42820000) + -63 (0xC27C0000) -> exponent 0x80, mantissa 0 (2.0).
  - 4 (0x40800000) + -4 (0xC0800000) -> all fields 0.
  - -0.5 + 0.5 -> all fields 0.
- Both negative: -99 (0xC2C60000) + -33 (0xC2040000) -> sign 1, exponent 0x86, mantissa 0x040000 (-132).
- Zero and rounding cases:
  - 0 + 12 (0x41400000) -> exactly 0x41400000.
  - 0.5 + 0xBE999998 -> 0x3E4CCCD0, i.e. the exact difference with no rounding error.
- Reset and specials:
  - rst high for 2 edges while driving 4 + -1 -> all outputs 0, then 3.0 one edge after rst falls.
  - +inf + -inf -> exponent 0xFF, mantissa 0x400000.
  - 0x7F7FFFFF + 0x7F7FFFFF -> +inf.

Source files
------------

// File: rtl/fp_add2.sv
// fp_add2: floating-point adder with one cycle of latency. Subnormals are flushed to zero.
// Rounding is round-to-nearest-even. The sign, exponent and mantissa outputs are registered.
module fp_add2 #(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] A_FP,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] B_FP,
    output logic                                  sign,
    output logic [EXPONENT_WIDTH-1:0]             exponent,
    output logic [MANTISSA_WIDTH-1:0]             mantissa
);
    localparam int E   = EXPONENT_WIDTH;
    localparam int M   = MANTISSA_WIDTH;
    localparam int SW  = M + 4;            // hidden + fraction + guard/round/sticky
    localparam int LZW = $clog2(SW + 1);
    localparam int XEW = E + 2;            // headroom for exponent under/overflow
    localparam logic [E-1:0]            EXP_ONES = '1;
    localparam logic signed [XEW-1:0]   EXP_MAX  = $signed({2'b00, EXP_ONES});

    function automatic logic [LZW-1:0] lzc(input logic [SW-1:0] v);
        logic [LZW-1:0] n;
        logic           found;
        n     = '0;
        found = 1'b0;
        for (int i = SW - 1; i >= 0; i--) begin
            if (v[i]) found = 1'b1;
            else if (!found) n = n + LZW'(1);
        end
        return n;
    endfunction

    function automatic logic [M+1:0] round_rne(input logic [SW-1:0] v);
        logic up;
        up = v[2] & (v[1] | v[0] | v[3]);
        return {1'b0, v[SW-1:3]} + (M + 2)'(up);
    endfunction

    logic         sa, sb;
    logic [E-1:0] ea, eb;
    logic [M-1:0] fa, fb;
    assign {sa, ea, fa} = A_FP;
    assign {sb, eb, fb} = B_FP;

    logic a_zero, b_zero, a_spec, b_spec, a_nan, b_nan, a_inf, b_inf;
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_spec = (ea == EXP_ONES);
    assign b_spec = (eb == EXP_ONES);
    assign a_nan  = a_spec && (fa != '0);
    assign b_nan  = b_spec && (fb != '0);
    assign a_inf  = a_spec && (fa == '0);
    assign b_inf  = b_spec && (fb == '0);

    logic                  swap, s_big;
    logic [E-1:0]          e_big, e_small, e_diff;
    logic [SW-1:0]         big_ext, small_ext, small_al, norm;
    logic [SW:0]           sum;
    logic [LZW-1:0]        lz;
    logic signed [XEW-1:0] exp_n;
    logic [M+1:0]          rnd;
    logic [M-1:0]          frac_r;
    logic                  sign_d, sign_q;
    logic [E-1:0]          exp_d, exp_q;
    logic [M-1:0]          mant_d, mant_q;

    always_comb begin
        sign_d = 1'b0;
        exp_d  = '0;
        mant_d = '0;

        // Order by magnitude so the subtraction never goes negative.
        swap      = {eb, fb} > {ea, fa};
        s_big     = swap ? sb : sa;
        e_big     = swap ? eb : ea;
        e_small   = swap ? ea : eb;
        big_ext   = {1'b1, (swap ? fb : fa), 3'b000};
        small_ext = {1'b1, (swap ? fa : fb), 3'b000};
        e_diff    = e_big - e_small;

        if (int'(e_diff) >= M + 3) begin
            small_al = {{(SW-1){1'b0}}, 1'b1};
        end else begin
            small_al    = small_ext >> e_diff;
            small_al[0] = small_al[0] | ((small_ext & ~({SW{1'b1}} << e_diff)) != '0);
        end

        if (sa == sb) sum = {1'b0, big_ext} + {1'b0, small_al};
        else          sum = {1'b0, big_ext} - {1'b0, small_al};

        lz = lzc(sum[SW-1:0]);
        if (sum[SW]) begin
            norm  = {sum[SW:2], sum[1] | sum[0]};
            exp_n = $signed({2'b00, e_big}) + XEW'(1);
        end else begin
            norm  = sum[SW-1:0] << lz;
            exp_n = $signed({2'b00, e_big}) - $signed(XEW'(lz));
        end

        rnd = round_rne(norm);
        if (rnd[M+1]) begin
            frac_r = rnd[M:1];
            exp_n  = exp_n + XEW'(1);
        end else begin
            frac_r = rnd[M-1:0];
        end

        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            exp_d  = EXP_ONES;
            mant_d = {1'b1, {(M-1){1'b0}}};
        end else if (a_inf) begin
            sign_d = sa;
            exp_d  = EXP_ONES;
        end else if (b_inf) begin
            sign_d = sb;
            exp_d  = EXP_ONES;
        end else if (a_zero && b_zero) begin
            sign_d = 1'b0;
        end else if (a_zero) begin
            {sign_d, exp_d, mant_d} = B_FP;
        end else if (b_zero) begin
            {sign_d, exp_d, mant_d} = A_FP;
        end else if ((sum == '0) || (exp_n <= 0)) begin
            sign_d = 1'b0;
        end else if (exp_n >= EXP_MAX) begin
            sign_d = s_big;
            exp_d  = EXP_ONES;
        end else begin
            sign_d = s_big;
            exp_d  = exp_n[E-1:0];
            mant_d = frac_r;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q <= 1'b0;
            exp_q  <= '0;
            mant_q <= '0;
        end else begin
            sign_q <= sign_d;
            exp_q  <= exp_d;
            mant_q <= mant_d;
        end
    end

    assign sign     = sign_q;
    assign exponent = exp_q;
    assign mantissa = mant_q;
endmodule

// File: tb/tb_fp_add2.sv
// Testbench for fp_add2 (binary32). It runs directed cases and then random cases.
// Random results are compared against a reference model that adds in double precision.
module tb_fp_add2;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] A_FP, B_FP;
  logic        sign;
  logic [7:0]  exponent;
  logic [22:0] mantissa;
  int          total = 0;
  int          bad   = 0;

  fp_add2 #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23)) dut (
    .clk(clk), .rst(rst), .A_FP(A_FP), .B_FP(B_FP),
    .sign(sign), .exponent(exponent), .mantissa(mantissa)
  );

  always #5 clk = ~clk;

  function automatic real to_real(input logic [31:0] x);
    if (x[30:23] == 8'h00) return 0.0;
    return $bitstoreal({x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'b0});
  endfunction

  // Round an exact double to 24-bit precision, then flush underflow to +0 and overflow to infinity.
  function automatic logic [31:0] from_real(input real r);
    logic [63:0] d;
    logic [52:0] sig;
    logic [24:0] m;
    logic [28:0] rem;
    int          e2, be;
    logic        up;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'h0;
    e2  = int'(d[62:52]) - 1023;
    sig = {1'b1, d[51:0]};
    rem = sig[28:0];
    up  = (rem > 29'h10000000) || ((rem == 29'h10000000) && sig[29]);
    m   = {1'b0, sig[52:29]} + 25'(up);
    if (m[24]) begin
      m  = m >> 1;
      e2 = e2 + 1;
    end
    be = e2 + 127;
    if (be <= 0)   return 32'h0;
    if (be >= 255) return {d[63], 8'hFF, 23'h0};
    return {d[63], 8'(be), m[22:0]};
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic a_nan, b_nan, a_inf, b_inf;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) return 32'h7FC00000;
    if (a_inf) return a;
    if (b_inf) return b;
    if ((a[30:23] == 0) && (b[30:23] == 0)) return 32'h0;
    if (a[30:23] == 0) return b;
    if (b[30:23] == 0) return a;
    return from_real(to_real(a) + to_real(b));
  endfunction

  task automatic check(input string tag, input logic [31:0] exp_v);
    logic [31:0] obs;
    obs   = {sign, exponent, mantissa};
    total = total + 1;
    assert (obs === exp_v) else begin
      bad = bad + 1;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] b);
    A_FP = a;
    B_FP = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          ea, eb;
    rst  = 1'b1;
    A_FP = 32'h0;
    B_FP = 32'h0;
    @(posedge clk);
    #1;
    check("reset_init", 32'h0);

    step(32'h40800000, 32'hBF800000); check("reset_hold1", 32'h0);
    step(32'h40800000, 32'hBF800000); check("reset_hold2", 32'h0);
    rst = 1'b0;
    step(32'h40800000, 32'hBF800000); check("4_minus_1", 32'h40400000);

    step(32'h40E80000, 32'h3EC00000); check("7.25_plus_0.375", 32'h40F40000);
    step(32'h40C00000, 32'h40E00000); check("6_plus_7", 32'h41500000);
    step(32'h42820000, 32'hC27C0000); check("65_minus_63", 32'h40000000);
    step(32'h40800000, 32'hC0800000); check("4_minus_4", 32'h0);
    step(32'hBF000000, 32'h3F000000); check("neg_half_plus_half", 32'h0);
    step(32'hC2C60000, 32'hC2040000); check("both_negative", 32'hC3040000);
    step(32'h00000000, 32'h41400000); check("zero_plus_12", 32'h41400000);
    step(32'h3F000000, 32'hBE999998); check("exact_diff", 32'h3E4CCCD0);
    step(32'h7F800000, 32'hFF800000); check("inf_minus_inf", 32'h7FC00000);
    step(32'h7F7FFFFF, 32'h7F7FFFFF); check("overflow", 32'h7F800000);
    step(32'h7FA00001, 32'h3F800000); check("nan_operand", 32'h7FC00000);
    step(32'hFF800000, 32'h40A00000); check("neg_inf_pass", 32'hFF800000);
    step(32'h3F800000, 32'h30800000); check("sticky_only", 32'h3F800000);
    step(32'h3F800000, 32'h33800000); check("tie_to_even", 32'h3F800000);
    step(32'h3F800000, 32'h33C00000); check("above_half", 32'h3F800001);
    step(32'h00800001, 32'h80800000); check("underflow_flush", 32'h0);
    step(32'h00000001, 32'h3F800000); check("subnormal_is_zero", 32'h3F800000);

    for (int i = 0; i < 400; i++) begin
      case (i % 4)
        0: begin
          ra = $urandom;
          rb = $urandom;
        end
        1, 2: begin
          ea = int'($urandom_range(110, 150));
          eb = ea + int'($urandom_range(0, 30)) - 15;
          ra = {1'($urandom), 8'(ea), 23'($urandom)};
          rb = {1'($urandom), 8'(eb), 23'($urandom)};
        end
        default: begin
          ea = int'($urandom_range(60, 200));
          ra = {1'($urandom), 8'(ea), 23'($urandom)};
          rb = {~ra[31], ra[30:0] ^ ($urandom & 32'h0000003F)};
        end
      endcase
      step(ra, rb);
      check("random", ref_add(ra, rb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
